// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM slot scheduler.
// Build option TDM_PARITY_EN appends one even-parity bit to every slot.
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int slot_bits(input int width);
`ifdef TDM_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Bits needed for a counter spanning 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_chan_buf.sv
// Single-word holding buffer for one TDM channel: accept on valid/ready,
// release on slot load. An accept and a load never coincide because load needs full.
module tdm_chan_buf #(
  parameter int WIDTH = 16
) (
  input  logic             sclk,
  input  logic             rstn,
  input  logic             valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] data_out
);

  logic             full_d, full_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b0;
    end
    if (valid && !full_q) begin
      full_d = 1'b1;
      data_d = data_in;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready    = !full_q;
  assign full     = full_q;
  assign data_out = data_q;

endmodule

// File: rtl/tdm_slot_sched.sv
// Frame sequencer for the AudioNet link: walks NCH slots and shifts each channel's word MSB-first.
// Build option TDM_PARITY_EN sends an even-parity bit after each slot's LSB.
//
// state | meaning
// IDLE  | link quiet, counters parked at 0, waiting for enable
// RUN   | one bit per sclk; frame end decides between RUN and IDLE
module tdm_slot_sched
  import tdm_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
) (
  input  logic                 sclk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [NCH-1:0]       ch_valid,
  input  logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]       ch_ready,
  output logic                 sdata,
  output logic                 sfs,
  output logic [NCH-1:0]       underrun
);

  localparam int SLOT_BITS = slot_bits(WIDTH);
  localparam int BW        = cnt_w(SLOT_BITS);
  localparam int SW        = cnt_w(NCH);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NCH - 1);

  state_e          state_d, state_q;
  logic [BW-1:0]   bit_cnt_d, bit_cnt_q;
  logic [SW-1:0]   slot_cnt_d, slot_cnt_q;

  logic             sdata_d, sdata_q;
  logic             sfs_d, sfs_q;
  logic [NCH-1:0]   underrun_d, underrun_q;
  logic [WIDTH-1:0] shift_d, shift_q;
`ifdef TDM_PARITY_EN
  logic             par_d, par_q;
`endif

  logic [NCH-1:0]   full;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] buf_data [NCH];

  logic emit, bit_last, slot_last;

  // The IDLE edge that samples enable already emits bit 0 of the frame
  assign emit      = (state_q == RUN) || enable;
  assign bit_last  = (bit_cnt_q == BIT_LAST);
  assign slot_last = (slot_cnt_q == SLOT_LAST);

  for (genvar i = 0; i < NCH; i++) begin : g_buf
    tdm_chan_buf #(
      .WIDTH(WIDTH)
    ) u_buf (
      .sclk    (sclk),
      .rstn    (rstn),
      .valid   (ch_valid[i]),
      .data_in (ch_data[i*WIDTH +: WIDTH]),
      .load    (load[i]),
      .ready   (ch_ready[i]),
      .full    (full[i]),
      .data_out(buf_data[i])
    );
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (emit) begin
      state_d = RUN;
      if (bit_last) begin
        bit_cnt_d = '0;
        if (slot_last) begin
          slot_cnt_d = '0;
          state_d    = enable ? RUN : IDLE;
        end else begin
          slot_cnt_d = slot_cnt_q + SW'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    sdata_d    = 1'b0;
    sfs_d      = 1'b0;
    underrun_d = '0;
    load       = '0;
    shift_d    = shift_q;
`ifdef TDM_PARITY_EN
    par_d      = par_q;
`endif
    if (emit) begin
      if (bit_cnt_q == '0) begin
        sfs_d = (slot_cnt_q == '0);
        if (full[slot_cnt_q]) begin
          load[slot_cnt_q] = 1'b1;
          sdata_d          = buf_data[slot_cnt_q][WIDTH-1];
          shift_d          = {buf_data[slot_cnt_q][WIDTH-2:0], 1'b0};
`ifdef TDM_PARITY_EN
          par_d            = ^buf_data[slot_cnt_q];
`endif
        end else begin
          underrun_d[slot_cnt_q] = 1'b1;
          shift_d                = '0;
`ifdef TDM_PARITY_EN
          par_d                  = 1'b0;
`endif
        end
`ifdef TDM_PARITY_EN
      end else if (bit_last) begin
        sdata_d = par_q;
`endif
      end else begin
        sdata_d = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      sdata_q    <= 1'b0;
      sfs_q      <= 1'b0;
      underrun_q <= '0;
      shift_q    <= '0;
`ifdef TDM_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      sdata_q    <= sdata_d;
      sfs_q      <= sfs_d;
      underrun_q <= underrun_d;
      shift_q    <= shift_d;
`ifdef TDM_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign sdata    = sdata_q;
  assign sfs      = sfs_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_tdm_slot_sched.sv
// Directed bench for tdm_slot_sched with NCH=4, WIDTH=16; follows TDM_PARITY_EN when defined.
module tb_tdm_slot_sched;

`ifdef TDM_PARITY_EN
  localparam int SB = 17;
`else
  localparam int SB = 16;
`endif
  localparam int FB = 4 * SB;

  logic        sclk;
  logic        rstn;
  logic        enable;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic [3:0]  ch_ready;
  logic        sdata;
  logic        sfs;
  logic [3:0]  underrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] w [4];

  tdm_slot_sched #(.NCH(4), .WIDTH(16)) dut (
    .sclk    (sclk),
    .rstn    (rstn),
    .enable  (enable),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .sdata   (sdata),
    .sfs     (sfs),
    .underrun(underrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [15:0] word, input logic present, input int k);
    if (!present) return 1'b0;
    if (k < 16) return word[15-k];
    return ^word;
  endfunction

  task automatic load_ch(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) ch_data[i*16 +: 16] = w[i];
    ch_valid = mask;
    tick();
    ch_valid = 4'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++; if (sdata !== 1'b0) begin n_err++; $display("FAIL reset_sdata got %b exp 0", sdata); end
    n_cmp++; if (sfs !== 1'b0) begin n_err++; $display("FAIL reset_sfs got %b exp 0", sfs); end
    n_cmp++; if (underrun !== 4'b0) begin n_err++; $display("FAIL reset_underrun got %b exp 0000", underrun); end
    n_cmp++; if (ch_ready !== 4'b1111) begin n_err++; $display("FAIL reset_ready got %b exp 1111", ch_ready); end
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (sfs !== 1'b0 || sdata !== 1'b0) begin n_err++; $display("FAIL idle_quiet c=%0d got sfs=%b sdata=%b exp 0 0", c, sfs, sdata); end
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] exp_rdy;
    w[0] = 16'hA5A5; w[1] = 16'h1234; w[2] = 16'hFFFF; w[3] = 16'h0001;
    load_ch(4'b1111);
    n_cmp++; if (ch_ready !== 4'b0000) begin n_err++; $display("FAIL full_accept_ready got %b exp 0000", ch_ready); end
    enable = 1'b1;
    for (int c = 0; c < FB; c++) begin
      tick();
      n_cmp++; if (sdata !== exp_bit(w[c/SB], 1'b1, c%SB)) begin n_err++; $display("FAIL full_sdata c=%0d got %b exp %b", c, sdata, exp_bit(w[c/SB], 1'b1, c%SB)); end
      n_cmp++; if (sfs !== (c == 0)) begin n_err++; $display("FAIL full_sfs c=%0d got %b exp %b", c, sfs, (c == 0)); end
      n_cmp++; if (underrun !== 4'b0) begin n_err++; $display("FAIL full_underrun c=%0d got %b exp 0000", c, underrun); end
      for (int i = 0; i < 4; i++) exp_rdy[i] = (c >= i*SB);
      n_cmp++; if (ch_ready !== exp_rdy) begin n_err++; $display("FAIL full_ready c=%0d got %b exp %b", c, ch_ready, exp_rdy); end
    end
    tick();
    n_cmp++; if (sfs !== 1'b1) begin n_err++; $display("FAIL full_next_sfs got %b exp 1", sfs); end
    n_cmp++; if (underrun !== 4'b0001) begin n_err++; $display("FAIL full_next_underrun got %b exp 0001", underrun); end
    enable = 1'b0;
    for (int c = 1; c < FB; c++) begin
      tick();
      n_cmp++; if (sdata !== 1'b0) begin n_err++; $display("FAIL empty_sdata c=%0d got %b exp 0", c, sdata); end
      n_cmp++; if (underrun !== ((c%SB == 0) ? (4'b0001 << (c/SB)) : 4'b0000)) begin n_err++; $display("FAIL empty_underrun c=%0d got %b", c, underrun); end
    end
    tick();
    n_cmp++; if (sfs !== 1'b0) begin n_err++; $display("FAIL full_stop_sfs got %b exp 0", sfs); end
  endtask

  task automatic test_underrun();
    logic [3:0] mask;
    logic [3:0] exp_ur;
    mask = 4'b1011;
    w[0] = 16'h8421; w[1] = 16'h5A5A; w[2] = 16'hFFFF; w[3] = 16'hC001;
    load_ch(mask);
    n_cmp++; if (ch_ready !== 4'b0100) begin n_err++; $display("FAIL ur_accept_ready got %b exp 0100", ch_ready); end
    enable = 1'b1;
    for (int c = 0; c < FB; c++) begin
      tick();
      if (c == 0) enable = 1'b0;
      exp_ur = (c%SB == 0 && !mask[c/SB]) ? (4'b0001 << (c/SB)) : 4'b0000;
      n_cmp++; if (sdata !== exp_bit(w[c/SB], mask[c/SB], c%SB)) begin n_err++; $display("FAIL ur_sdata c=%0d got %b exp %b", c, sdata, exp_bit(w[c/SB], mask[c/SB], c%SB)); end
      n_cmp++; if (underrun !== exp_ur) begin n_err++; $display("FAIL ur_underrun c=%0d got %b exp %b", c, underrun, exp_ur); end
      n_cmp++; if (sfs !== (c == 0)) begin n_err++; $display("FAIL ur_sfs c=%0d got %b exp %b", c, sfs, (c == 0)); end
    end
    tick();
    n_cmp++; if (sfs !== 1'b0 || sdata !== 1'b0) begin n_err++; $display("FAIL ur_stop got sfs=%b sdata=%b exp 0 0", sfs, sdata); end
  endtask

  task automatic test_enable_drop();
    w[0] = 16'h8001; w[1] = 16'h7FFE; w[2] = 16'hF00F; w[3] = 16'h0FF0;
    load_ch(4'b1111);
    enable = 1'b1;
    for (int c = 0; c < FB; c++) begin
      tick();
      if (c == 10) enable = 1'b0;
      n_cmp++; if (sdata !== exp_bit(w[c/SB], 1'b1, c%SB)) begin n_err++; $display("FAIL drop_sdata c=%0d got %b exp %b", c, sdata, exp_bit(w[c/SB], 1'b1, c%SB)); end
      n_cmp++; if (sfs !== (c == 0)) begin n_err++; $display("FAIL drop_sfs c=%0d got %b exp %b", c, sfs, (c == 0)); end
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if (sfs !== 1'b0 || sdata !== 1'b0) begin n_err++; $display("FAIL drop_after c=%0d got sfs=%b sdata=%b exp 0 0", c, sfs, sdata); end
    end
  endtask

  task automatic test_simul_accept();
    w[0] = 16'hC3A5;
    ch_data[15:0] = w[0];
    ch_valid = 4'b0001;
    enable = 1'b1;
    for (int c = 0; c < FB; c++) begin
      tick();
      if (c == 0) begin
        ch_valid = 4'b0;
        n_cmp++; if (ch_ready !== 4'b1110) begin n_err++; $display("FAIL simul_ready got %b exp 1110", ch_ready); end
      end
      n_cmp++; if (sdata !== 1'b0) begin n_err++; $display("FAIL simul_sdata c=%0d got %b exp 0", c, sdata); end
      n_cmp++; if (underrun !== ((c%SB == 0) ? (4'b0001 << (c/SB)) : 4'b0000)) begin n_err++; $display("FAIL simul_underrun c=%0d got %b", c, underrun); end
    end
    tick();
    enable = 1'b0;
    n_cmp++; if (sfs !== 1'b1) begin n_err++; $display("FAIL simul_next_sfs got %b exp 1", sfs); end
    n_cmp++; if (underrun !== 4'b0000) begin n_err++; $display("FAIL simul_next_underrun got %b exp 0000", underrun); end
    n_cmp++; if (sdata !== 1'b1) begin n_err++; $display("FAIL simul_next_msb got %b exp 1", sdata); end
    for (int k = 1; k < SB; k++) begin
      tick();
      n_cmp++; if (sdata !== exp_bit(w[0], 1'b1, k)) begin n_err++; $display("FAIL simul_word k=%0d got %b exp %b", k, sdata, exp_bit(w[0], 1'b1, k)); end
    end
    for (int c = SB; c < FB; c++) tick();
    tick();
    n_cmp++; if (sfs !== 1'b0) begin n_err++; $display("FAIL simul_stop_sfs got %b exp 0", sfs); end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    int sfs_seen;
    w[0] = 16'h0001; w[1] = 16'h0; w[2] = 16'h0; w[3] = 16'h0;
    load_ch(4'b0001);
    enable = 1'b1;
    sfs_seen = 0;
    for (int c = 0; c < FB; c++) begin
      tick();
      if (sfs) sfs_seen++;
      n_cmp++; if (sdata !== exp_bit(w[0], (c < SB), c)) begin n_err++; $display("FAIL par_sdata c=%0d got %b exp %b", c, sdata, exp_bit(w[0], (c < SB), c)); end
      if (c == 16) begin
        n_cmp++; if (sdata !== 1'b1) begin n_err++; $display("FAIL par_bit got %b exp 1", sdata); end
      end
    end
    n_cmp++; if (sfs_seen !== 1) begin n_err++; $display("FAIL par_sfs_count got %0d exp 1", sfs_seen); end
    tick();
    enable = 1'b0;
    n_cmp++; if (sfs !== 1'b1) begin n_err++; $display("FAIL par_period got %b exp 1 at cycle 68", sfs); end
    for (int c = 1; c < FB; c++) tick();
    tick();
  endtask
`endif

  task automatic test_reset_midframe();
    w[0] = 16'hFFFF; w[1] = 16'hFFFF; w[2] = 16'hFFFF; w[3] = 16'hFFFF;
    load_ch(4'b1111);
    enable = 1'b1;
    for (int c = 0; c <= 20; c++) tick();
    rstn = 1'b0;
    #1;
    n_cmp++; if (sdata !== 1'b0) begin n_err++; $display("FAIL mid_rst_sdata got %b exp 0", sdata); end
    n_cmp++; if (sfs !== 1'b0) begin n_err++; $display("FAIL mid_rst_sfs got %b exp 0", sfs); end
    n_cmp++; if (underrun !== 4'b0) begin n_err++; $display("FAIL mid_rst_underrun got %b exp 0000", underrun); end
    n_cmp++; if (ch_ready !== 4'b1111) begin n_err++; $display("FAIL mid_rst_ready got %b exp 1111", ch_ready); end
    enable = 1'b0;
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 2*FB; c++) begin
      tick();
      n_cmp++; if (sfs !== 1'b0 || sdata !== 1'b0) begin n_err++; $display("FAIL mid_rst_quiet c=%0d got sfs=%b sdata=%b exp 0 0", c, sfs, sdata); end
    end
  endtask

  initial begin
    rstn     = 1'b0;
    enable   = 1'b0;
    ch_valid = 4'b0;
    ch_data  = 64'b0;
    test_reset();
    test_full_frame();
    test_underrun();
    test_enable_drop();
    test_simul_accept();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_slot_sched.md
# tdm_slot_sched

Time-division scheduler that shares the single AudioNet serial link (sdata/sfs on sclk) between NCH audio channel sources. Each channel offers one sample word per frame through a valid/ready handshake. The block sequences the frame: it asserts frame sync, walks the slots in fixed order, and shifts each channel's buffered word MSB-first. It replaces free-running pattern generation on the link with real per-channel traffic and reports per-slot underruns.

## Interface
- NCH, 4: number of channels/slots per frame (2..16)
- WIDTH, 16: sample bits per slot (8..32)
- sclk  input  1  serial bit clock; all logic on posedge
- rstn  input  1  reset; asynchronous, active-low
- enable  input  1  run request; sampled at frame boundaries
- ch_valid  input  NCH  per-channel sample valid
- ch_data  input  NCH*WIDTH  samples, channel i at [i*WIDTH +: WIDTH]
- ch_ready  output  NCH  per-channel buffer empty (accept possible)
- sdata  output  1  serial data, registered
- sfs  output  1  frame sync, registered, high on the first bit of a frame
- underrun  output  NCH  one-cycle pulse when slot i starts with no buffered sample

## Operation
- Per-channel holding register plus full flag. ch_ready[i] = !full[i]. Transfer occurs on an edge where ch_valid[i] && ch_ready[i]; full[i] sets.
- SLOT_BITS = WIDTH (+1 with parity, see Configuration). FRAME_BITS = NCH*SLOT_BITS.
- Counters: bit_cnt 0..SLOT_BITS-1 and slot_cnt 0..NCH-1. Both wrap to 0.
- States:
  - IDLE: sdata=0, sfs=0, counters held at 0. Go to RUN on the first edge where enable=1.
  - RUN: advance one bit per sclk. At the last bit of the last slot, stay in RUN if enable=1, else go to IDLE.
- Enable dropping mid-frame does not truncate: the current frame completes through bit FRAME_BITS-1.
- Slot load happens on the edge that emits bit 0 of slot i:
  - full[i]=1: the word loads into the shift register, sdata takes its MSB, and full[i] clears.
  - full[i]=0: zeros are shifted for the whole slot and underrun[i] pulses on that edge.
- Simultaneous accept and slot load on channel i: no bypass. The slot reports underrun. The new word is held and sent in the next frame.
- Holding registers keep their contents across IDLE periods. A word accepted while IDLE goes out in the next frame.
- rstn low at any time, including mid-frame: immediately IDLE, all full flags cleared, counters 0.

## Timing
- Reset values: sdata=0, sfs=0, underrun=0, ch_ready all 1.
- Start latency: from the IDLE edge that samples enable=1, the same edge registers sfs=1 and sdata=bit WIDTH-1 of channel 0.
- sfs is high for exactly one cycle per frame, every FRAME_BITS cycles while running.
- Slot i bit k appears at frame cycle i*SLOT_BITS+k.
- ch_ready[i] falls one edge after acceptance. It rises on the edge after that channel's slot load.
- underrun[i] is coincident with bit 0 of slot i.

## Configuration
- TDM_PARITY_EN defined:
  - SLOT_BITS = WIDTH+1.
  - After the LSB, one even-parity bit is sent, equal to the XOR of the WIDTH data bits.
  - Underrun slots send parity 0.
- Undefined: SLOT_BITS = WIDTH and no parity bit is sent.

## Structure
- Package tdm_pkg holds:
  - state enum (IDLE, RUN)
  - function slot_bits(width), which applies the TDM_PARITY_EN adjustment
  - counter-width localparam helpers using $clog2
- Sub-module tdm_chan_buf: one holding register, full flag, ready, and clear-on-load. Instantiated NCH times in a generate loop.

## Test plan
All scenarios use NCH=4, WIDTH=16.
1. Reset release -> sdata=0, sfs=0, underrun=0, ch_ready=4'b1111. Assert rstn at frame bit 20 -> outputs return to these values on the next sampled cycle and no further sfs occurs.
2. Load ch0..3 = 16'hA5A5, 16'h1234, 16'hFFFF, 16'h0001, then enable=1 -> sfs at cycle 0, sdata stream matches the words MSB-first over 64 cycles, next sfs at cycle 64, ch_ready all 1 after their slots.
3. Leave ch2 unloaded -> bits 32..47 are 0, underrun=4'b0100 pulses at cycle 32, other slots are intact.
4. Drop enable at frame bit 10 -> transmission continues through bit 63, then sdata=0 with no sfs at cycle 64.
5. Present ch0 valid on the edge of the slot-0 load, with full[0]=0 -> underrun[0] pulses and slot 0 is zero. The word appears at bit 0 of the next frame.
6. With TDM_PARITY_EN, ch0 = 16'h0001 -> slot is 17 bits ending in 1, frame is 68 cycles, and sfs period is 68.
